lsu_mem_ctrl: RTL

- Load/store controller between the RV32IM execute stage and the 4-bank data SRAM block.
- Accepts one load/store request at a time over a valid/ready handshake.
- Drives the SRAM command port: enable, write/read, byte-select code, word address and lane-aligned write data.
- Extracts and sign/zero-extends load data. Performs read-modify-write for byte stores the SRAM byte-select code cannot express, and flags misaligned or out-of-range accesses.

---
 rtl/lsu_mem_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between the execute stage and the 4-bank data SRAM.
// Issues one request at a time. Byte stores at offsets 1/2 are done as read-modify-write.
module lsu_mem_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int MEM_ADDR_BITS = 14
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic                  lsu_req_we,
  input  logic [2:0]            lsu_req_funct3,
  input  logic [ADDR_WIDTH-1:0] lsu_req_addr,
  input  logic [DATA_WIDTH-1:0] lsu_req_wdata,
  output logic                  lsu_rsp_valid,
  output logic [DATA_WIDTH-1:0] lsu_rsp_rdata,
  output logic                  lsu_rsp_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic                  data_out_en,
  output logic [2:0]            mem_byte_sel,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write,
  input  logic [DATA_WIDTH-1:0] data_out
);

  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, MERGE_WR, RESP} state_t;

  state_t                state_reg, state_next;
  logic                  we_reg;
  logic [2:0]            funct3_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic                  err_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic [DATA_WIDTH-1:0] merge_reg;

  logic                  accept;
  logic                  req_err;
  logic                  rmw;
  logic [1:0]            offset;
  logic [7:0]            load_byte;
  logic [15:0]           load_half;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [DATA_WIDTH-1:0] merge_next;

  assign accept = lsu_req_valid && lsu_req_ready;
  assign offset = addr_reg[1:0];
  assign rmw    = we_reg && (funct3_reg == 3'b000) && (offset == 2'b01 || offset == 2'b10);

  // Request legality is judged on the raw inputs and only its registered copy is used later
  always_comb begin
    req_err = 1'b0;
    if (lsu_req_we) begin
      case (lsu_req_funct3)
        3'b000:  req_err = 1'b0;
        3'b001:  req_err = lsu_req_addr[0];
        3'b010:  req_err = |lsu_req_addr[1:0];
        default: req_err = 1'b1;
      endcase
    end else begin
      case (lsu_req_funct3)
        3'b000, 3'b100: req_err = 1'b0;
        3'b001, 3'b101: req_err = lsu_req_addr[0];
        3'b010:         req_err = |lsu_req_addr[1:0];
        default:        req_err = 1'b1;
      endcase
    end
    if (|lsu_req_addr[ADDR_WIDTH-1:MEM_ADDR_BITS]) req_err = 1'b1;
  end

  assign load_byte = data_out[8*offset +: 8];
  assign load_half = data_out[16*offset[1] +: 16];

  always_comb begin
    case (funct3_reg)
      3'b000:  load_ext = {{(DATA_WIDTH-8){load_byte[7]}}, load_byte};
      3'b001:  load_ext = {{(DATA_WIDTH-16){load_half[15]}}, load_half};
      3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, load_byte};
      3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, load_half};
      default: load_ext = data_out;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH/8; gi++) begin : g_merge
      assign merge_next[8*gi +: 8] = (offset == gi) ? wdata_reg[7:0] : data_out[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      we_reg     <= 1'b0;
      funct3_reg <= 3'b000;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      err_reg    <= 1'b0;
      rdata_reg  <= '0;
      merge_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        we_reg     <= lsu_req_we;
        funct3_reg <= lsu_req_funct3;
        addr_reg   <= lsu_req_addr;
        wdata_reg  <= lsu_req_wdata;
        err_reg    <= req_err;
        rdata_reg  <= '0;
      end
      if (state_reg == CAPTURE) begin
        if (rmw) merge_reg <= merge_next;
        else     rdata_reg <= load_ext;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    lsu_req_ready = 1'b0;
    lsu_rsp_valid = 1'b0;
    lsu_rsp_rdata = '0;
    lsu_rsp_err   = 1'b0;
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_re        = 1'b0;
    data_out_en   = 1'b0;
    mem_byte_sel  = 3'b010;
    mem_addr      = '0;
    mem_write     = '0;
    case (state_reg)
      IDLE: begin
        lsu_req_ready = 1'b1;
        if (lsu_req_valid) state_next = req_err ? RESP : ISSUE;
      end
      ISSUE: begin
        mem_en   = 1'b1;
        mem_addr = {addr_reg[ADDR_WIDTH-1:2], 2'b00};
        if (we_reg && !rmw) begin
          mem_we = 1'b1;
          case (funct3_reg)
            3'b000: begin
              if (offset == 2'b00) begin
                mem_byte_sel = 3'b000;
                mem_write    = {{(DATA_WIDTH-8){1'b0}}, wdata_reg[7:0]};
              end else begin
                mem_byte_sel = 3'b100;
                mem_write    = {wdata_reg[7:0], {(DATA_WIDTH-8){1'b0}}};
              end
            end
            3'b001: begin
              if (offset[1]) begin
                mem_byte_sel = 3'b101;
                mem_write    = {wdata_reg[15:0], {(DATA_WIDTH-16){1'b0}}};
              end else begin
                mem_byte_sel = 3'b001;
                mem_write    = {{(DATA_WIDTH-16){1'b0}}, wdata_reg[15:0]};
              end
            end
            default: mem_write = wdata_reg;
          endcase
          state_next = RESP;
        end else begin
          mem_re      = 1'b1;
          data_out_en = 1'b1;
          state_next  = CAPTURE;
        end
      end
      CAPTURE: state_next = rmw ? MERGE_WR : RESP;
      MERGE_WR: begin
        mem_en     = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = {addr_reg[ADDR_WIDTH-1:2], 2'b00};
        mem_write  = merge_reg;
        state_next = RESP;
      end
      RESP: begin
        lsu_rsp_valid = 1'b1;
        lsu_rsp_rdata = rdata_reg;
        lsu_rsp_err   = err_reg;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
